uart_rx: RTL



---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and the
// default frame format. Intended to be reused by the transmitter as well.
package uart_rx_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    // Sample ticks per bit period; a power of two >= 8
    localparam int OVS = 16;

    // Default frame format: 8 data bits, one stop bit (16 ticks)
    localparam int DEF_DBIT  = 8;
    localparam int DEF_SB_TK = 16;

    // Larger of two integers, used when sizing shared counters
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for bringing an asynchronous single-bit
// input into the i_clk domain. Both flops reset to RESET_VAL so the
// output shows the line's idle level straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state values: simply shift the input down the two-stage chain
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Synchroniser flops, forced to the idle level on reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with OVS-times oversampling. Deserialises an asynchronous,
// idle-high serial line (start bit, DBIT data bits LSB first, SB_TK-tick
// stop period, no parity) into parallel words, pulsing o_rx_done_tick for
// one cycle per completed frame and flagging a low stop bit on o_frame_err.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT  = DEF_DBIT,
    parameter int SB_TK = DEF_SB_TK
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_data,
    output logic            o_frame_err
);

    localparam int SW = $clog2(max_int(OVS, SB_TK));
    localparam int NW = $clog2(DBIT);

    // Tick counts at which the FSM acts
    localparam logic [SW-1:0] S_MID       = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    logic            rx_s;

    logic [1:0]      state_q,   state_d;
    logic [SW-1:0]   s_q,       s_d;
    logic [NW-1:0]   n_q,       n_d;
    logic [DBIT-1:0] b_q,       b_d;
    logic [DBIT-1:0] data_q,    data_d;
    logic            done_q,    done_d;
    logic            ferr_q,    ferr_d;
    logic            stop_ok_q, stop_ok_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // Frame FSM: detect start, sample each bit at its centre, then time the
    // stop period and hand the word out. stop_ok is taken 8 ticks into STOP.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        stop_ok_d = stop_ok_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            STOP: begin
                if (i_s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        data_d  = b_q;
                        done_d  = 1'b1;
                        ferr_d  = ~stop_ok_q;
                    end else begin
                        if (s_q == S_MID) begin
                            stop_ok_d = rx_s;
                        end
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop_ok_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            stop_ok_q <= stop_ok_d;
        end
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;

endmodule
